// File: rtl/zz_rle_pkg.sv
// Shared constants and token layout for the zigzag run-length stage, its
// upstream scan stage and the downstream entropy coder.
package zz_rle_pkg;

    localparam int DATA_WIDTH = 10;
    localparam int BLK_SIZE   = 64;
    localparam int IDX_W      = 6;
    localparam int RUN_W      = 6;
    localparam int NZ_W       = 7;
    localparam int EOB_W      = 1;
    localparam int LEVEL_W    = DATA_WIDTH;
    localparam int TOKEN_W    = RUN_W + LEVEL_W + EOB_W + NZ_W;

    typedef struct packed {
        logic [RUN_W-1:0]   run;
        logic [LEVEL_W-1:0] level;
        logic               eob;
        logic [NZ_W-1:0]    nz_cnt;
    } token_t;

    function automatic token_t make_token(
        input logic [RUN_W-1:0]   run,
        input logic [LEVEL_W-1:0] level,
        input logic               eob,
        input logic [NZ_W-1:0]    nz_cnt
    );
        token_t t;
        t.run    = run;
        t.level  = level;
        t.eob    = eob;
        t.nz_cnt = nz_cnt;
        return t;
    endfunction

endpackage

// File: rtl/zz_rle.sv
// Zigzag run-length encoder: turns a stream of 8x8 zigzag-ordered coefficients
// into (run, level) tokens, closing each block with an eob-marked token.
module zz_rle
    import zz_rle_pkg::*;
#(
    parameter int DATA_WIDTH = zz_rle_pkg::DATA_WIDTH,
    parameter int BLK_SIZE   = zz_rle_pkg::BLK_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vld_in,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  vld_out,
    output logic [RUN_W-1:0]      run,
    output logic [DATA_WIDTH-1:0] level,
    output logic                  eob,
    output logic [NZ_W-1:0]       nz_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_SIZE - 1);

    logic [IDX_W-1:0]      idx_r;
    logic [RUN_W-1:0]      zrun_r;
    logic [NZ_W-1:0]       nzc_r;
    logic                  vld_out_r;
    logic [RUN_W-1:0]      run_r;
    logic [DATA_WIDTH-1:0] level_r;
    logic                  eob_r;
    logic [NZ_W-1:0]       nz_cnt_r;

    logic                  is_dc_s;
    logic                  is_last_s;
    logic                  din_zero_s;
    logic                  emit_s;

    // Position and zero classification of the current input coefficient.
    always_comb begin
        is_dc_s    = (idx_r == {IDX_W{1'b0}});
        is_last_s  = (idx_r == LAST_IDX);
        din_zero_s = (din == {DATA_WIDTH{1'b0}});
        if (vld_in) begin
            emit_s = is_dc_s | is_last_s | ~din_zero_s;
        end else begin
            emit_s = 1'b0;
        end
    end

    // Block state and registered token outputs; a zero AC only grows the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r     <= {IDX_W{1'b0}};
            zrun_r    <= {RUN_W{1'b0}};
            nzc_r     <= {NZ_W{1'b0}};
            vld_out_r <= 1'b0;
            run_r     <= {RUN_W{1'b0}};
            level_r   <= {DATA_WIDTH{1'b0}};
            eob_r     <= 1'b0;
            nz_cnt_r  <= {NZ_W{1'b0}};
        end else if (vld_in) begin
            idx_r     <= is_last_s ? {IDX_W{1'b0}} : idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            vld_out_r <= emit_s;
            eob_r     <= is_last_s;
            if (is_dc_s) begin
                run_r   <= {RUN_W{1'b0}};
                level_r <= din;
                zrun_r  <= {RUN_W{1'b0}};
                nzc_r   <= {NZ_W{1'b0}};
            end else if (is_last_s) begin
                // Trailing zeros are dropped: a zero last coefficient becomes a bare EOB.
                zrun_r <= {RUN_W{1'b0}};
                if (din_zero_s) begin
                    run_r    <= {RUN_W{1'b0}};
                    level_r  <= {DATA_WIDTH{1'b0}};
                    nz_cnt_r <= nzc_r;
                end else begin
                    run_r    <= zrun_r;
                    level_r  <= din;
                    nz_cnt_r <= nzc_r + {{(NZ_W-1){1'b0}}, 1'b1};
                end
            end else if (!din_zero_s) begin
                run_r   <= zrun_r;
                level_r <= din;
                zrun_r  <= {RUN_W{1'b0}};
                nzc_r   <= nzc_r + {{(NZ_W-1){1'b0}}, 1'b1};
            end else begin
                zrun_r <= zrun_r + {{(RUN_W-1){1'b0}}, 1'b1};
            end
        end else begin
            vld_out_r <= 1'b0;
            eob_r     <= 1'b0;
        end
    end

    assign vld_out = vld_out_r;
    assign run     = run_r;
    assign level   = level_r;
    assign eob     = eob_r;
    assign nz_cnt  = nz_cnt_r;

endmodule

// File: tb/tb_zz_rle.sv
// Directed bench for zz_rle: expected tokens are queued with the input index
// that must produce them and checked one cycle after that input.
module tb_zz_rle;

    logic       clk;
    logic       rst_n;
    logic       vld_in;
    logic [9:0] din;
    logic       vld_out;
    logic [5:0] run;
    logic [9:0] level;
    logic       eob;
    logic [6:0] nz_cnt;

    typedef struct {
        int         idx;
        logic [5:0] run;
        logic [9:0] level;
        logic       eob;
        logic [6:0] nz;
    } tok_t;

    tok_t       exp_q[$];
    logic [9:0] coef[64];
    logic [9:0] last_level;
    logic [5:0] last_run;
    int         tests;
    int         failed;

    zz_rle dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_in (vld_in),
        .din    (din),
        .vld_out(vld_out),
        .run    (run),
        .level  (level),
        .eob    (eob),
        .nz_cnt (nz_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_tok(input int i, input logic [5:0] r, input logic [9:0] l,
                            input logic e, input logic [6:0] n);
        tok_t t;
        t.idx = i; t.run = r; t.level = l; t.eob = e; t.nz = n;
        exp_q.push_back(t);
    endtask

    // One cycle: drive at negedge, DUT samples at posedge, check at next negedge.
    task automatic step(input logic v, input logic [9:0] d, input int k, input string tag);
        tok_t t;
        logic want;
        vld_in = v;
        din    = d;
        @(posedge clk);
        @(negedge clk);
        want = v && (exp_q.size() > 0) && (exp_q[0].idx == k);
        chk({tag, ".vld_out"}, {31'd0, vld_out}, {31'd0, want});
        if (want) begin
            t = exp_q.pop_front();
            chk({tag, ".run"},   {26'd0, run},   {26'd0, t.run});
            chk({tag, ".level"}, {22'd0, level}, {22'd0, t.level});
            chk({tag, ".eob"},   {31'd0, eob},   {31'd0, t.eob});
            if (t.eob) chk({tag, ".nz_cnt"}, {25'd0, nz_cnt}, {25'd0, t.nz});
            last_level = t.level;
            last_run   = t.run;
        end else begin
            chk({tag, ".hold_level"}, {22'd0, level}, {22'd0, last_level});
            chk({tag, ".hold_run"},   {26'd0, run},   {26'd0, last_run});
        end
    endtask

    task automatic send_coefs(input int n, input int maxgap, input string tag);
        for (int k = 0; k < n; k++) begin
            int g;
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            for (int j = 0; j < g; j++) step(1'b0, 10'h155, -1, {tag, ".gap"});
            step(1'b1, coef[k], k, tag);
        end
        vld_in = 1'b0;
    endtask

    task automatic load_req030();
        for (int k = 0; k < 64; k++) coef[k] = 10'd0;
        coef[0]  = 10'd5;
        coef[3]  = -10'sd2;
        coef[10] = 10'd7;
    endtask

    task automatic push_req030();
        push_tok(0,  6'd0, 10'd5,   1'b0, 7'd0);
        push_tok(3,  6'd2, -10'sd2, 1'b0, 7'd0);
        push_tok(10, 6'd6, 10'd7,   1'b0, 7'd0);
        push_tok(63, 6'd0, 10'd0,   1'b1, 7'd2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".vld_out"}, {31'd0, vld_out}, 32'd0);
        chk({tag, ".run"},     {26'd0, run},     32'd0);
        chk({tag, ".level"},   {22'd0, level},   32'd0);
        chk({tag, ".eob"},     {31'd0, eob},     32'd0);
        chk({tag, ".nz_cnt"},  {25'd0, nz_cnt},  32'd0);
    endtask

    initial begin
        tests = 0; failed = 0;
        rst_n = 1'b0; vld_in = 1'b0; din = 10'd0;
        last_level = 10'd0; last_run = 6'd0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero block: DC token and a bare EOB.
        for (int k = 0; k < 64; k++) coef[k] = 10'd0;
        push_tok(0,  6'd0, 10'd0, 1'b0, 7'd0);
        push_tok(63, 6'd0, 10'd0, 1'b1, 7'd0);
        send_coefs(64, 0, "zeros");

        load_req030();
        push_req030();
        send_coefs(64, 0, "sparse");

        // 62 zero ACs then a nonzero last coefficient.
        for (int k = 0; k < 64; k++) coef[k] = 10'd0;
        coef[0]  = -10'sd3;
        coef[63] = 10'd1;
        push_tok(0,  6'd0,  -10'sd3, 1'b0, 7'd0);
        push_tok(63, 6'd62, 10'd1,   1'b1, 7'd1);
        send_coefs(64, 0, "lastnz");

        // Two back-to-back all-ones blocks.
        for (int k = 0; k < 64; k++) coef[k] = 10'd1;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 64; k++) push_tok(k, 6'd0, 10'd1, (k == 63), 7'd63);
            send_coefs(64, 0, "ones");
        end

        load_req030();
        push_req030();
        send_coefs(64, 3, "gapped");

        // Partial block interrupted by reset, then a clean block.
        push_tok(0,  6'd0, 10'd5,   1'b0, 7'd0);
        push_tok(3,  6'd2, -10'sd2, 1'b0, 7'd0);
        push_tok(10, 6'd6, 10'd7,   1'b0, 7'd0);
        send_coefs(20, 0, "partial");
        chk("partial.q_empty", exp_q.size(), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        last_level = 10'd0; last_run = 6'd0;
        step(1'b0, 10'd0, -1, "post_reset_idle");
        push_req030();
        send_coefs(64, 0, "after_reset");

        step(1'b0, 10'd0, -1, "tail");
        chk("final.q_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/zz_rle.md
ZZ_RLE -- requirements
Module: zz_rle

Interface
REQ-001 Parameter DATA_WIDTH, default 10, SHALL set the coefficient and level width.
REQ-002 Parameter BLK_SIZE, default 64, SHALL set the coefficients per block (8x8, zigzag order).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 vld_in  input  1  SHALL qualify din; a high cycle SHALL carry one zigzag-ordered coefficient.
REQ-006 din  input  DATA_WIDTH  SHALL carry a two's-complement coefficient.
REQ-007 vld_out  output  1  SHALL qualify run, level, eob and nz_cnt.
REQ-008 run  output  6  SHALL give the count of zero coefficients preceding level.
REQ-009 level  output  DATA_WIDTH  SHALL give the nonzero coefficient value, or 0 on an EOB token.
REQ-010 eob  output  1  SHALL mark the last token of a block.
REQ-011 nz_cnt  output  7  SHALL give the block's nonzero AC count; it SHALL be meaningful only when vld_out and eob are both high.

Function
REQ-012 The block SHALL keep a 6-bit coefficient index idx, advancing only on vld_in and wrapping 63->0.
REQ-013 The block SHALL keep a 6-bit zero-run counter zrun and a 7-bit nonzero counter nzc.
REQ-014 Cycles with vld_in low SHALL hold all state and drive vld_out low; the input may have arbitrary gaps.
REQ-015 idx==0 (DC): the block SHALL emit run=0, level=din, eob=0 unconditionally (zero DC included), and SHALL clear zrun and nzc.
REQ-016 0<idx<63 with din!=0: the block SHALL emit run=zrun, level=din, eob=0, clear zrun and increment nzc.
REQ-017 0<idx<63 with din==0: the block SHALL emit nothing and increment zrun.
REQ-018 idx==63 with din!=0: the block SHALL emit run=zrun, level=din, eob=1, nz_cnt=nzc+1.
REQ-019 idx==63 with din==0: the block SHALL emit the EOB token run=0, level=0, eob=1, nz_cnt=nzc; pending trailing zeros SHALL be discarded.
REQ-020 All outputs SHALL be registered; latency from a vld_in cycle to its token SHALL be exactly 1 cycle.
REQ-021 The block SHALL produce at most one token per input cycle and SHALL have no backpressure.
REQ-022 Back-to-back blocks SHALL be accepted with no idle cycle; the idx==0 sample after idx==63 SHALL start a new block.
REQ-023 zrun SHALL NOT exceed 62; no saturation logic is needed.
REQ-024 run, level and nz_cnt SHALL hold their last values while vld_out is low.

Reset
REQ-025 Asserting rst_n low SHALL asynchronously clear idx, zrun, nzc, vld_out, run, level, eob and nz_cnt to 0.
REQ-026 A reset asserted mid-block SHALL discard the partial block without emitting eob; the first vld_in after release SHALL be treated as DC (idx 0).

Structure
REQ-027 A shared package SHALL hold DATA_WIDTH, BLK_SIZE, RUN_W=6, NZ_W=7 and the token field widths, for reuse by the upstream scan stage and the downstream entropy coder.
REQ-028 The block SHALL be a single module with no sub-modules; the zero-detect and index compare SHALL be inline logic.

Verification
REQ-029 Reset released, then 64 zeros contiguous -> two tokens: (0,0,eob=0) one cycle after idx0, then (0,0,eob=1,nz_cnt=0) one cycle after idx63.
REQ-030 Block din[0]=5, din[3]=-2, din[10]=7, all others 0 -> tokens (0,5), (2,-2), (6,7), then (0,0,eob=1,nz_cnt=2).
REQ-031 Block with din[63]=1 after 62 zero ACs -> tokens (0,DC) then (62,1,eob=1,nz_cnt=1).
REQ-032 Two back-to-back all-ones blocks -> 128 consecutive tokens of run=0, level=1, with eob on tokens 64 and 128 and nz_cnt=63 on each.
REQ-033 Same stimulus as REQ-030 with vld_in randomly gapped 0-3 cycles -> identical token sequence, each token exactly 1 cycle after its input.
REQ-034 rst_n pulsed low after 20 coefficients, then a full clean block -> no eob emitted for the partial block; the clean block's tokens match REQ-030.
